// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and transmitter state encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBITS data bits LSB first, optional parity, SBITS stop bits,
// each bit 16 s_tick pulses long. Parity bit is added when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int SBITS      = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [DBITS-1:0] din,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int            BW        = $clog2(DBITS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);
    localparam logic          STOP_LAST = 1'(SBITS - 1);

    if (DBITS < 5 || DBITS > 9 || SBITS < 1 || SBITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_param_check
        $error("uart_tx: DBITS, SBITS or PARITY_ODD out of range");
    end

    tx_state_e        state_q, state_d;
    logic [3:0]       tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [DBITS-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latches).
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = din;
                    tick_d  = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^din) ^ 1'(PARITY_ODD);
`endif
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (stop_q == STOP_LAST) begin
                            stop_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered, so its next level follows the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every cycle,
// plus directed frames with hand-derived bit strings and tick counts.
module tb_uart_tx;

    localparam int DBITS  = 8;
    localparam int SBITS  = 1;
    localparam int PODD   = 0;
    localparam int SBITS2 = 2;
    localparam int PODD2  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS       = 1 + DBITS + PAR + SBITS;
    localparam int FRAME_TICKS = 16 * NBITS;
    localparam int LIT_FRAME   = (PAR != 0) ? 176 : 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx, tx_busy, tx_done;
    logic       tx_start2 = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic       tx2, busy2, done2;

    always #5 clk = ~clk;

    uart_tx #(.DBITS(DBITS), .SBITS(SBITS), .PARITY_ODD(PODD)) u_dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.DBITS(DBITS), .SBITS(SBITS2), .PARITY_ODD(PODD2)) u_dut2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start2), .din(din2),
        .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitted bit string in line order for one frame of the main instance.
    function automatic string fr(input string data_lsb_first, input string par);
        string p;
        p = "";
`ifdef UART_TX_PARITY_EN
        p = par;
`endif
        return {"0", data_lsb_first, p, "1"};
    endfunction

    // Tick source: 0 = silent, 1 = every tick_period clocks, 2 = random with tick_pct percent.
    int tick_mode   = 0;
    int tick_period = 4;
    int tick_pct    = 50;
    int tick_cnt    = 0;

    always @(posedge clk) begin
        #1;
        tick_cnt = (tick_cnt + 1) % tick_period;
        case (tick_mode)
            1:       s_tick = (tick_cnt == 0);
            2:       s_tick = ($urandom_range(0, 99) < tick_pct);
            default: s_tick = 1'b0;
        endcase
    end

    // Reference model: a frame is a list of NBITS line levels, each held for 16 counted ticks.
    logic m_active = 1'b0;
    logic m_done   = 1'b0;
    int   m_n      = 0;
    logic m_bits [0:15];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_n      = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (tx_start) begin
                    m_active  = 1'b1;
                    m_n       = 0;
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < DBITS; i++) m_bits[1 + i] = din[i];
                    if (PAR != 0) m_bits[1 + DBITS] = (^din) ^ 1'(PODD);
                    for (int s = 0; s < SBITS; s++) m_bits[1 + DBITS + PAR + s] = 1'b1;
                end
            end else if (s_tick) begin
                m_n++;
                if (m_n == FRAME_TICKS) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    end

    string cap = "";
    int    busy_ticks = 0;
    int    done_cnt = 0;
    int    low2 = 0, high2 = 0, done2_cnt = 0;
    logic  par2 = 1'b0;

    always @(negedge clk) begin
        check("tx", tx, m_active ? m_bits[m_n / 16] : 1'b1);
        check("tx_busy", tx_busy, m_active);
        check("tx_done", tx_done, m_done);
        if (m_active && s_tick && (m_n % 16) == 8) cap = {cap, tx ? "1" : "0"};
        if (tx_busy && s_tick) busy_ticks++;
        if (tx_done) done_cnt++;
        if (busy2 && s_tick) begin
            if (low2 + high2 == 152) par2 = tx2;
            if (tx2) high2++;
            else low2++;
        end
        if (done2) done2_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        din      = d;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        din      = 8'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (tx_done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        check({name, "_done_seen"}, tx_done, 1);
    endtask

    task automatic wait_ticks(input int target);
        int k;
        k = 0;
        while (m_active && m_n < target && k < 5000) begin
            step();
            k++;
        end
    endtask

    task automatic frame(input string name, input logic [7:0] d, input string exp);
        cap        = "";
        busy_ticks = 0;
        done_cnt   = 0;
        send(d);
        wait_done(name, 20000);
        step();
        check_str({name, "_bits"}, cap, exp);
        check({name, "_ticks"}, busy_ticks, LIT_FRAME);
        check({name, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic d2_frame(input string name, input logic [7:0] d, input int exp_low,
                            input int exp_high, input logic exp_par);
        int k;
        low2      = 0;
        high2     = 0;
        done2_cnt = 0;
        din2      = d;
        tx_start2 = 1'b1;
        step();
        tx_start2 = 1'b0;
        k = 0;
        while (done2 !== 1'b1 && k < 20000) begin
            step();
            k++;
        end
        check({name, "_done_seen"}, done2, 1);
        step();
        check({name, "_low_ticks"}, low2, exp_low);
        check({name, "_high_ticks"}, high2, exp_high);
        check({name, "_done_cnt"}, done2_cnt, 1);
`ifdef UART_TX_PARITY_EN
        check({name, "_parity"}, par2, exp_par);
`else
        check({name, "_idle_after"}, tx2, exp_par | 1'b1);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) step();
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        rst = 1'b1;
        tick_mode   = 1;
        tick_period = 4;
        repeat (5) step();

        frame("basic_55", 8'h55, fr("10101010", "0"));
        frame("pattern_a5", 8'hA5, fr("10100101", "0"));

        // Request while busy must be ignored and must not queue.
        cap = ""; busy_ticks = 0; done_cnt = 0;
        send(8'hA3);
        wait_ticks(16 * 3 + 4);
        din = 8'hFF; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        wait_done("busy_ignore", 20000);
        repeat (300) step();
        check_str("busy_ignore_bits", cap, fr("11000101", "0"));
        check("busy_ignore_ticks", busy_ticks, LIT_FRAME);
        check("busy_ignore_done_cnt", done_cnt, 1);

        // Back-to-back: request held through the tx_done cycle.
        cap = ""; busy_ticks = 0; done_cnt = 0;
        send(8'h0F);
        wait_ticks(FRAME_TICKS - 4);
        din = 8'hF0; tx_start = 1'b1;
        wait_done("b2b_first", 20000);
        check("b2b_gap_idle_level", tx, 1);
        step();
        tx_start = 1'b0;
        check("b2b_second_start", tx, 0);
        check("b2b_second_busy", tx_busy, 1);
        wait_done("b2b_second", 20000);
        step();
        check_str("b2b_bits", cap, {fr("11110000", "0"), fr("00001111", "0")});
        check("b2b_ticks", busy_ticks, 2 * LIT_FRAME);
        check("b2b_done_cnt", done_cnt, 2);

        // Stalled tick source: line holds mid data bit 1 (din[1] of 0x55 is 0).
        send(8'h55);
        wait_ticks(16 * 2 + 8);
        tick_mode = 0;
        repeat (60) step();
        check("stall_tx", tx, 0);
        check("stall_busy", tx_busy, 1);
        tick_mode = 1;
        wait_done("stall_resume", 20000);
        step();

        // Asynchronous reset during data bit 3, then a clean frame.
        send(8'h55);
        wait_ticks(16 * 4 + 4);
        done_cnt = 0;
        #2 rst = 1'b0;
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_busy", tx_busy, 0);
        check("midreset_done", tx_done, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (40) step();
        check("midreset_no_done", done_cnt, 0);
        frame("after_reset_81", 8'h81, fr("10000001", "0"));

        // Two stop bits, odd parity instance.
`ifdef UART_TX_PARITY_EN
        d2_frame("sbits2_00", 8'h00, 144, 48, 1'b1);
        d2_frame("sbits2_a5", 8'hA5, 80, 112, 1'b1);
`else
        d2_frame("sbits2_00", 8'h00, 144, 32, 1'b1);
        d2_frame("sbits2_a5", 8'hA5, 80, 96, 1'b1);
`endif

        // Randomized frames, tick patterns and spurious requests.
        for (int f = 0; f < 25; f++) begin
            int k;
            if ($urandom_range(0, 1) == 1) begin
                tick_mode   = 1;
                tick_period = $urandom_range(1, 6);
            end else begin
                tick_mode = 2;
                tick_pct  = $urandom_range(20, 80);
            end
            send(8'($urandom));
            k = 0;
            while (tx_done !== 1'b1 && k < 20000) begin
                if ($urandom_range(0, 49) == 0 && m_n < FRAME_TICKS - 32) begin
                    tx_start = 1'b1;
                    din      = 8'($urandom);
                end else begin
                    tx_start = 1'b0;
                end
                step();
                k++;
            end
            tx_start = 1'b0;
            check($sformatf("rand%0d_done_seen", f), tx_done, 1);
            repeat ($urandom_range(0, 4)) step();
        end
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
